aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
// - Control FSM for an iterative, one-round-per-cycle AES datapath: AddRoundKey, SubBytes, ShiftRows, MixColumns.
// - Sits between the SPI command layer and the round datapath.
// - Decodes the 2-bit key-size code into Nr, steps the round counter and selects the round key from the expanded schedule w.
// - Drives per-round datapath enables and reports done/valid/error.
// PARAMETERS
// - RK_W   4  width of round-key select / round index (covers 0..14)
// - NR_128 10 rounds for key code 2'b00
// - NR_192 12 rounds for key code 2'b01
// - NR_256 14 rounds for key code 2'b10
// PORTS
// - clk        in   1     single clock; all state changes on posedge
// - rst        in   1     synchronous, active-high reset
// - start      in   1     request a new block; sampled only in IDLE
// - key_size   in   2     00=AES-128, 01=AES-192, 10=AES-256, 11=invalid; sampled with start
// - abort      in   1     cancel the block in flight
// - busy       out  1     high from INIT through FINAL
// - round_idx  out  RK_W  current round number, 0..Nr
// - rk_sel     out  RK_W  word-block index into w: key bits [128*rk_sel +: 128]
// - load_state out  1     datapath loads plaintext XOR rk (INIT only)
// - sub_shift  out  1     enable SubBytes+ShiftRows (ROUND, FINAL)
// - mix_en     out  1     enable MixColumns (ROUND only)
// - last_round out  1     high in FINAL
// - done       out  1     1-cycle pulse: result register valid this cycle
// - out_valid  out  1     level; set with done, cleared by the next accepted start, abort or rst
// - err        out  1     1-cycle pulse: start rejected (key_size=11)
// - nr         out  RK_W  latched Nr of the current/last block
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, round_idx=0, rk_sel=0, nr=0, all 1-bit outputs 0. rst overrides every other input.
// - States and transitions:
//   - IDLE: start & valid key_size -> INIT; latch nr; round_idx=0; clear out_valid.
//   - IDLE: start & key_size=11 -> stay IDLE; err=1 for 1 cycle; nr and out_valid unchanged.
//   - INIT: load_state=1, rk_sel=0. Next cycle -> ROUND with round_idx=1.
//   - ROUND: sub_shift=1, mix_en=1, rk_sel=round_idx. round_idx increments each cycle; when round_idx==nr-1 -> FINAL next.
//   - FINAL: round_idx=nr, sub_shift=1, mix_en=0, last_round=1. Next cycle -> DONE.
//   - DONE: done=1, out_valid=1, busy=0. Next cycle -> IDLE.
// - Latency: start sampled at cycle t, INIT at t+1, done at t+nr+2. AES-128: 12 cycles; AES-256: 16 cycles.
// - Back-to-back: start may be asserted in the DONE cycle but is ignored; first acceptance is in the following IDLE cycle.
// - start while busy or in DONE: ignored, no err.
// - abort in INIT/ROUND/FINAL: -> IDLE next cycle; no done pulse; out_valid=0; round_idx=0.
// - abort in IDLE or DONE: no effect on state. In IDLE, abort & start in the same cycle: abort wins, start dropped.
// - All control outputs are registered (Moore); the datapath samples them in the same cycle they are high.
// - Counter never exceeds nr; no wrap beyond 14.
// CONFIGURATION
// - AES_DECRYPT_EN defined:
//   - Adds input port `dir` (1 bit, sampled with start; 0=encrypt, 1=decrypt) and output `inv` (latched dir).
//   - Decrypt: rk_sel = nr - round_idx, so INIT uses rk nr and FINAL uses rk 0.
//   - inv tells the datapath to select its inverse S-box, inverse ShiftRows and inverse MixColumns. Timing is identical.
// - AES_DECRYPT_EN undefined: no dir/inv ports; rk_sel = round_idx always (encryption only).
// TESTING
// - rst, then start with key_size=00 -> INIT next cycle, rk_sel 0,1..9 then 10 in FINAL, mix_en=0 only in FINAL; done 12 cycles after start; nr=10.
// - key_size=10 -> done 16 cycles after start, last_round with round_idx=14; out_valid held until next start.
// - start with key_size=11 -> err pulse 1 cycle, busy stays 0, no state change.
// - AES-192 start, abort at round_idx=5 -> IDLE next cycle, no done, out_valid=0; a new start is then accepted normally.
// - start re-asserted every cycle during a block -> ignored; second block begins only after DONE->IDLE; rst mid-ROUND -> all outputs 0 next cycle.
// - AES_DECRYPT_EN, dir=1, key_size=00 -> rk_sel sequence 10,9..1,0; inv=1 throughout; done 12 cycles after start.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative one-round-per-cycle AES datapath: key-size decode, round
// counting, round-key select and registered per-round enables. Decrypt option: AES_DECRYPT_EN.
module aes_round_sequencer #(
    parameter int unsigned RK_W   = 4,
    parameter int unsigned NR_128 = 10,
    parameter int unsigned NR_192 = 12,
    parameter int unsigned NR_256 = 14
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_key_size,
    input  logic            i_abort,
`ifdef AES_DECRYPT_EN
    input  logic            i_dir,
    output logic            o_inv,
`endif
    output logic            o_busy,
    output logic [RK_W-1:0] o_round_idx,
    output logic [RK_W-1:0] o_rk_sel,
    output logic            o_load_state,
    output logic            o_sub_shift,
    output logic            o_mix_en,
    output logic            o_last_round,
    output logic            o_done,
    output logic            o_out_valid,
    output logic            o_err,
    output logic [RK_W-1:0] o_nr
);

    typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

    state_e          r_state;
    logic [RK_W-1:0] r_round_idx, r_rk_sel, r_nr;
    logic            r_busy, r_load_state, r_sub_shift, r_mix_en, r_last_round;
    logic            r_done, r_out_valid, r_err, r_inv;

    logic [RK_W-1:0] w_nr_dec;
    logic            w_key_ok;
    logic            w_dir;
    logic [RK_W-1:0] w_idx_next;
    logic [RK_W-1:0] w_rk_next;
    logic [RK_W-1:0] w_rk_final;
    logic [RK_W-1:0] w_rk_init;

`ifdef AES_DECRYPT_EN
    assign w_dir = i_dir;
    assign o_inv = r_inv;
`else
    assign w_dir = 1'b0;
`endif

    always_comb begin
        w_key_ok = 1'b1;
        unique case (i_key_size)
            2'b00:   w_nr_dec = RK_W'(NR_128);
            2'b01:   w_nr_dec = RK_W'(NR_192);
            2'b10:   w_nr_dec = RK_W'(NR_256);
            default: begin
                w_nr_dec = '0;
                w_key_ok = 1'b0;
            end
        endcase
    end

    // Decrypt walks the schedule backwards: rk_sel = nr - round_idx.
    always_comb begin
        w_idx_next = r_round_idx + RK_W'(1);
        w_rk_next  = r_inv ? (r_nr - w_idx_next) : w_idx_next;
        w_rk_final = r_inv ? '0 : r_nr;
        w_rk_init  = w_dir ? w_nr_dec : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_round_idx  <= '0;
            r_rk_sel     <= '0;
            r_nr         <= '0;
            r_busy       <= 1'b0;
            r_load_state <= 1'b0;
            r_sub_shift  <= 1'b0;
            r_mix_en     <= 1'b0;
            r_last_round <= 1'b0;
            r_done       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_inv        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (i_abort && (r_state == StInit || r_state == StRound || r_state == StFinal)) begin
                r_state      <= StIdle;
                r_round_idx  <= '0;
                r_rk_sel     <= '0;
                r_busy       <= 1'b0;
                r_load_state <= 1'b0;
                r_sub_shift  <= 1'b0;
                r_mix_en     <= 1'b0;
                r_last_round <= 1'b0;
                r_out_valid  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        // Abort in IDLE drops a coincident start.
                        if (i_start && !i_abort) begin
                            if (w_key_ok) begin
                                r_state      <= StInit;
                                r_nr         <= w_nr_dec;
                                r_inv        <= w_dir;
                                r_round_idx  <= '0;
                                r_rk_sel     <= w_rk_init;
                                r_busy       <= 1'b1;
                                r_load_state <= 1'b1;
                                r_out_valid  <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    StInit: begin
                        r_state      <= StRound;
                        r_round_idx  <= w_idx_next;
                        r_rk_sel     <= w_rk_next;
                        r_load_state <= 1'b0;
                        r_sub_shift  <= 1'b1;
                        r_mix_en     <= 1'b1;
                    end
                    StRound: begin
                        if (r_round_idx == r_nr - RK_W'(1)) begin
                            r_state      <= StFinal;
                            r_round_idx  <= r_nr;
                            r_rk_sel     <= w_rk_final;
                            r_mix_en     <= 1'b0;
                            r_last_round <= 1'b1;
                        end else begin
                            r_round_idx <= w_idx_next;
                            r_rk_sel    <= w_rk_next;
                        end
                    end
                    StFinal: begin
                        r_state      <= StDone;
                        r_busy       <= 1'b0;
                        r_sub_shift  <= 1'b0;
                        r_last_round <= 1'b0;
                        r_done       <= 1'b1;
                        r_out_valid  <= 1'b1;
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_round_idx  = r_round_idx;
    assign o_rk_sel     = r_rk_sel;
    assign o_load_state = r_load_state;
    assign o_sub_shift  = r_sub_shift;
    assign o_mix_en     = r_mix_en;
    assign o_last_round = r_last_round;
    assign o_done       = r_done;
    assign o_out_valid  = r_out_valid;
    assign o_err        = r_err;
    assign o_nr         = r_nr;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer; covers the AES_DECRYPT_EN build when defined.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] key_size;
    logic       busy, load_state, sub_shift, mix_en, last_round, done, out_valid, err;
    logic [3:0] round_idx, rk_sel, nr;
`ifdef AES_DECRYPT_EN
    logic       dir, inv;
`endif

    int total = 0;
    int bad   = 0;
    int cnt;
    int lr_idx;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_key_size  (key_size),
        .i_abort     (abort),
`ifdef AES_DECRYPT_EN
        .i_dir       (dir),
        .o_inv       (inv),
`endif
        .o_busy      (busy),
        .o_round_idx (round_idx),
        .o_rk_sel    (rk_sel),
        .o_load_state(load_state),
        .o_sub_shift (sub_shift),
        .o_mix_en    (mix_en),
        .o_last_round(last_round),
        .o_done      (done),
        .o_out_valid (out_valid),
        .o_err       (err),
        .o_nr        (nr)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_size = 2'b00;
`ifdef AES_DECRYPT_EN
        dir = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_nr", int'(nr), 0);
        chk("rst_round_idx", int'(round_idx), 0);
        chk("rst_outs", int'({load_state, sub_shift, mix_en, last_round, done, out_valid, err}), 0);

        // AES-128: INIT, rounds 1..9, FINAL, DONE at the 12th edge
        start = 1'b1; key_size = 2'b00;
        step();
        start = 1'b0;
        chk("a128_init_load", int'(load_state), 1);
        chk("a128_init_busy", int'(busy), 1);
        chk("a128_init_rk", int'(rk_sel), 0);
        chk("a128_nr", int'(nr), 10);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("a128_round_rk", int'(rk_sel), k);
            chk("a128_round_en", int'({sub_shift, mix_en, load_state, last_round}), 4'b1100);
        end
        step();
        chk("a128_final_idx", int'(round_idx), 10);
        chk("a128_final_rk", int'(rk_sel), 10);
        chk("a128_final_en", int'({sub_shift, mix_en, last_round}), 3'b101);
        step();
        chk("a128_done", int'({done, out_valid, busy}), 3'b110);
        step();
        chk("a128_idle", int'({done, out_valid, busy}), 3'b010);

        // AES-256: count edges to done, sampling edge counts as 1
        start = 1'b1; key_size = 2'b10;
        cnt = 0; lr_idx = -1;
        step();
        start = 1'b0;
        cnt = 1;
        while (!done && cnt < 40) begin
            if (last_round) lr_idx = int'(round_idx);
            step();
            cnt++;
        end
        chk("a256_latency", cnt, 16);
        chk("a256_last_idx", lr_idx, 14);
        step(); step(); step();
        chk("a256_valid_held", int'(out_valid), 1);

        // Invalid key size
        start = 1'b1; key_size = 2'b11;
        step();
        start = 1'b0;
        chk("bad_err", int'(err), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_nr_kept", int'(nr), 14);
        chk("bad_valid_kept", int'(out_valid), 1);
        step();
        chk("bad_err_pulse", int'(err), 0);

        // AES-192 aborted at round 5
        start = 1'b1; key_size = 2'b01;
        step();
        start = 1'b0;
        chk("a192_nr", int'(nr), 12);
        chk("a192_valid_clr", int'(out_valid), 0);
        for (int k = 0; k < 5; k++) step();
        chk("a192_idx5", int'(round_idx), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", int'({busy, sub_shift, mix_en, out_valid}), 0);
        chk("abort_idx", int'(round_idx), 0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        // Start held high throughout: second block only after DONE->IDLE
        start = 1'b1; key_size = 2'b00;
        step();
        chk("b2b_init", int'(load_state), 1);
        for (int k = 0; k < 11; k++) step();
        chk("b2b_done", int'(done), 1);
        step();
        chk("b2b_idle", int'({busy, load_state, out_valid}), 3'b001);
        step();
        chk("b2b_restart", int'({busy, load_state, out_valid}), 3'b110);
        step(); step(); step();
        start = 1'b0;
        chk("b2b_round", int'(round_idx), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outs", int'({busy, load_state, sub_shift, mix_en, last_round, done,
                                  out_valid, err}), 0);
        chk("rst_mid_cnt", int'({nr, round_idx, rk_sel}), 0);

        // Abort and start together in IDLE: start dropped
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_wins", int'({busy, load_state, err}), 0);

`ifdef AES_DECRYPT_EN
        start = 1'b1; key_size = 2'b00; dir = 1'b1;
        step();
        start = 1'b0; dir = 1'b0;
        chk("dec_init_rk", int'(rk_sel), 10);
        chk("dec_inv", int'(inv), 1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("dec_round_rk", int'(rk_sel), 10 - k);
        end
        step();
        chk("dec_final_rk", int'(rk_sel), 0);
        chk("dec_final_inv", int'(inv), 1);
        step();
        chk("dec_done", int'(done), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
